sensor_ctrl_pio: RTL and testbench

Parametrised control/status peripheral for the phi/theta clock-sensor and TDC chain. It replaces the fixed 32-bit reset/lock PIO exports with one Avalon-MM slave. Per channel it provides a software-held reset level, a self-timing reset pulse of programmable length, a synchronised PLL-lock status bit, and a sticky loss-of-lock flag with a maskable interrupt. It sits on the Nios V data bus, next to the phi/theta PLLs and the TDC.

---
 rtl/sensor_ctrl_pkg.sv | 27 ++
 rtl/sensor_pulse_ch.sv | 35 +++
 rtl/sensor_ctrl_pio.sv | 119 +++++++++++
 tb/tb_sensor_ctrl_pio.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/sensor_ctrl_pkg.sv
// Shared constants for the sensor control PIO: register offsets, version and INFO layout.
package sensor_ctrl_pkg;

  localparam logic [2:0] ADDR_CTRL        = 3'd0;
  localparam logic [2:0] ADDR_PULSE       = 3'd1;
  localparam logic [2:0] ADDR_PULSE_LEN   = 3'd2;
  localparam logic [2:0] ADDR_LOCK_STATUS = 3'd3;
  localparam logic [2:0] ADDR_LOCK_LOST   = 3'd4;
  localparam logic [2:0] ADDR_IRQ_MASK    = 3'd5;
  localparam logic [2:0] ADDR_INFO        = 3'd6;

  localparam logic [15:0] VERSION = 16'h0001;

  localparam int INFO_NUM_CH_LSB   = 0;
  localparam int INFO_PULSE_W_LSB  = 8;
  localparam int INFO_VERSION_LSB  = 16;

  function automatic logic [31:0] info_word(input int num_ch, input int pulse_w);
    logic [31:0] w;
    w = '0;
    w[INFO_NUM_CH_LSB +: 8]   = 8'(num_ch);
    w[INFO_PULSE_W_LSB +: 8]  = 8'(pulse_w);
    w[INFO_VERSION_LSB +: 16] = VERSION;
    return w;
  endfunction

endpackage

// File: rtl/sensor_pulse_ch.sv
// One channel's self-timing reset pulse: a down-counter loaded on start, busy while non-zero.
module sensor_pulse_ch
  import sensor_ctrl_pkg::*;
#(
  parameter int PULSE_W = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [PULSE_W-1:0] len,
  output logic               busy,
  output logic               busy_nxt
);

  logic [PULSE_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (start) begin
      // a zero length still yields a single-cycle pulse
      cnt_d = (len == '0) ? PULSE_W'(1) : len;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - PULSE_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign busy     = (cnt_q != '0);
  assign busy_nxt = (cnt_d != '0);

endmodule

// File: rtl/sensor_ctrl_pio.sv
// Avalon-MM control/status slave for the phi/theta sensor and TDC chain: per-channel reset
// level and timed reset pulse, synchronised PLL lock and sticky loss-of-lock interrupt.
module sensor_ctrl_pio
  import sensor_ctrl_pkg::*;
#(
  parameter int NUM_CH        = 4,
  parameter int PULSE_W       = 16,
  parameter int SYNC_STAGES   = 2,
  parameter int PULSE_LEN_RST = 16
) (
  input  logic              clk_clk,
  input  logic              reset_reset,
  input  logic [2:0]        avs_address,
  input  logic              avs_read,
  input  logic              avs_write,
  input  logic [31:0]       avs_writedata,
  output logic [31:0]       avs_readdata,
  output logic              avs_readdatavalid,
  input  logic [NUM_CH-1:0] lock_in,
  output logic [NUM_CH-1:0] rst_out,
  output logic              irq
);

  logic [NUM_CH-1:0]                  ctrl_q, ctrl_d, mask_q, mask_d, lost_q, lost_d;
  logic [PULSE_W-1:0]                 len_q, len_d;
  logic [SYNC_STAGES-1:0][NUM_CH-1:0] sync_q, sync_d;
  logic [NUM_CH-1:0]                  hist_q, hist_d;
  logic [NUM_CH-1:0]                  rst_out_q, rst_out_d;
  logic [31:0]                        rdata_q, rdata_d;
  logic                               rvalid_q, rvalid_d;
  logic [NUM_CH-1:0]                  start, busy, busy_nxt, lock_sync, wr_ch, fall;
  logic                               unused_wdata;

  assign wr_ch        = avs_writedata[NUM_CH-1:0];
  assign lock_sync    = sync_q[SYNC_STAGES-1];
  assign fall         = hist_q & ~lock_sync;
  assign start        = (avs_write && avs_address == ADDR_PULSE) ? wr_ch : '0;
  assign unused_wdata = ^avs_writedata;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    sensor_pulse_ch #(.PULSE_W(PULSE_W)) u_ch (
      .clk      (clk_clk),
      .rst      (reset_reset),
      .start    (start[i]),
      .len      (len_q),
      .busy     (busy[i]),
      .busy_nxt (busy_nxt[i])
    );
  end

  always_comb begin
    ctrl_d = ctrl_q;
    len_d  = len_q;
    mask_d = mask_q;
    lost_d = lost_q;
    if (avs_write) begin
      case (avs_address)
        ADDR_CTRL:      ctrl_d = wr_ch;
        ADDR_PULSE_LEN: len_d  = avs_writedata[PULSE_W-1:0];
        ADDR_LOCK_LOST: lost_d = lost_q & ~wr_ch;
        ADDR_IRQ_MASK:  mask_d = wr_ch;
        default:        ;
      endcase
    end
    // a fresh loss edge wins over a same-cycle clear
    lost_d    = lost_d | fall;
    sync_d    = {sync_q[SYNC_STAGES-2:0], lock_in};
    hist_d    = lock_sync;
    rst_out_d = ctrl_d | busy_nxt;
  end

  always_comb begin
    rdata_d  = rdata_q;
    rvalid_d = avs_read;
    if (avs_read) begin
      rdata_d = '0;
      case (avs_address)
        ADDR_CTRL:        rdata_d[NUM_CH-1:0]  = ctrl_q;
        ADDR_PULSE:       rdata_d[NUM_CH-1:0]  = busy;
        ADDR_PULSE_LEN:   rdata_d[PULSE_W-1:0] = len_q;
        ADDR_LOCK_STATUS: rdata_d[NUM_CH-1:0]  = lock_sync;
        ADDR_LOCK_LOST:   rdata_d[NUM_CH-1:0]  = lost_q;
        ADDR_IRQ_MASK:    rdata_d[NUM_CH-1:0]  = mask_q;
        ADDR_INFO:        rdata_d              = info_word(NUM_CH, PULSE_W);
        default:          ;
      endcase
    end
  end

  always_ff @(posedge clk_clk or posedge reset_reset) begin
    if (reset_reset) begin
      ctrl_q    <= '1;
      len_q     <= PULSE_W'(PULSE_LEN_RST);
      mask_q    <= '0;
      lost_q    <= '0;
      sync_q    <= '0;
      hist_q    <= '0;
      rst_out_q <= '1;
      rdata_q   <= '0;
      rvalid_q  <= 1'b0;
    end else begin
      ctrl_q    <= ctrl_d;
      len_q     <= len_d;
      mask_q    <= mask_d;
      lost_q    <= lost_d;
      sync_q    <= sync_d;
      hist_q    <= hist_d;
      rst_out_q <= rst_out_d;
      rdata_q   <= rdata_d;
      rvalid_q  <= rvalid_d;
    end
  end

  assign rst_out           = rst_out_q;
  assign irq               = |(lost_q & mask_q);
  assign avs_readdata      = rdata_q;
  assign avs_readdatavalid = rvalid_q;

endmodule

// File: tb/tb_sensor_ctrl_pio.sv
// Scoreboard bench for sensor_ctrl_pio: cycle-indexed reference model, directed plan then random traffic.
module tb_sensor_ctrl_pio;

  localparam int NUM_CH        = 4;
  localparam int PULSE_W       = 16;
  localparam int SYNC_STAGES   = 2;
  localparam int PULSE_LEN_RST = 16;

  localparam logic [2:0] A_CTRL = 3'd0, A_PULSE = 3'd1, A_LEN = 3'd2, A_STAT = 3'd3,
                         A_LOST = 3'd4, A_MASK = 3'd5, A_INFO = 3'd6;

  logic              clk_clk = 1'b0;
  logic              reset_reset = 1'b1;
  logic [2:0]        avs_address = '0;
  logic              avs_read = 1'b0;
  logic              avs_write = 1'b0;
  logic [31:0]       avs_writedata = '0;
  logic [31:0]       avs_readdata;
  logic              avs_readdatavalid;
  logic [NUM_CH-1:0] lock_in = '1;
  logic [NUM_CH-1:0] rst_out;
  logic              irq;

  sensor_ctrl_pio #(
    .NUM_CH(NUM_CH), .PULSE_W(PULSE_W), .SYNC_STAGES(SYNC_STAGES), .PULSE_LEN_RST(PULSE_LEN_RST)
  ) dut (
    .clk_clk(clk_clk), .reset_reset(reset_reset), .avs_address(avs_address),
    .avs_read(avs_read), .avs_write(avs_write), .avs_writedata(avs_writedata),
    .avs_readdata(avs_readdata), .avs_readdatavalid(avs_readdatavalid),
    .lock_in(lock_in), .rst_out(rst_out), .irq(irq)
  );

  always #5 clk_clk = ~clk_clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: time is the count of clock edges since reset release. A pulse is the
  // interval of cycles [start, end]; lock status is lock_in delayed by SYNC_STAGES edges.
  logic [NUM_CH-1:0]  m_ctrl = '1, m_mask = '0, m_lost = '0;
  logic [PULSE_W-1:0] m_len = PULSE_W'(PULSE_LEN_RST);
  int                 pend [NUM_CH];
  logic [NUM_CH-1:0]  samp [int];
  int                 ecnt = 0;
  int                 rel_edge = 1;
  logic [31:0]        exp_q [$];
  logic [NUM_CH-1:0]  exp_rst = '1;
  logic               exp_irq = 1'b0;

  function automatic logic [NUM_CH-1:0] busy_at(input int c);
    logic [NUM_CH-1:0] b;
    for (int i = 0; i < NUM_CH; i++) b[i] = (c <= pend[i]);
    return b;
  endfunction

  function automatic logic [NUM_CH-1:0] stat(input int c);
    int e;
    e = c - SYNC_STAGES + 1;
    if (e < rel_edge || !samp.exists(e)) return '0;
    return samp[e];
  endfunction

  task automatic model_update();
    logic [31:0]       rb;
    logic [NUM_CH-1:0] w, fall;
    int                k, plen;
    if (reset_reset) begin
      m_ctrl = '1; m_mask = '0; m_lost = '0;
      m_len  = PULSE_W'(PULSE_LEN_RST);
      for (int i = 0; i < NUM_CH; i++) pend[i] = -1;
      samp.delete();
      exp_q.delete();
      rel_edge = ecnt + 1;
      exp_rst  = '1;
      exp_irq  = 1'b0;
      return;
    end
    k    = ecnt + 1;
    ecnt = k;
    w    = avs_writedata[NUM_CH-1:0];
    if (avs_read) begin
      rb = '0;
      case (avs_address)
        A_CTRL:  rb[NUM_CH-1:0]  = m_ctrl;
        A_PULSE: rb[NUM_CH-1:0]  = busy_at(k - 1);
        A_LEN:   rb[PULSE_W-1:0] = m_len;
        A_STAT:  rb[NUM_CH-1:0]  = stat(k - 1);
        A_LOST:  rb[NUM_CH-1:0]  = m_lost;
        A_MASK:  rb[NUM_CH-1:0]  = m_mask;
        A_INFO:  rb = 32'h0001_0000 + 32'(PULSE_W * 256) + 32'(NUM_CH);
        default: rb = '0;
      endcase
      exp_q.push_back(rb);
    end
    fall = stat(k - 2) & ~stat(k - 1);
    if (avs_write) begin
      case (avs_address)
        A_CTRL: m_ctrl = w;
        A_LEN:  m_len  = avs_writedata[PULSE_W-1:0];
        A_MASK: m_mask = w;
        A_LOST: m_lost = m_lost & ~w;
        A_PULSE: begin
          plen = (m_len == '0) ? 1 : int'(m_len);
          for (int i = 0; i < NUM_CH; i++) if (w[i]) pend[i] = k + plen - 1;
        end
        default: ;
      endcase
    end
    m_lost  = m_lost | fall;
    samp[k] = lock_in;
    exp_rst = m_ctrl | busy_at(k);
    exp_irq = |(m_lost & m_mask);
  endtask

  initial begin
    for (int i = 0; i < NUM_CH; i++) pend[i] = -1;
    forever begin
      @(posedge clk_clk or posedge reset_reset);
      model_update();
    end
  end

  // Monitor: compares every cycle, popping the scoreboard whenever read data is presented.
  initial begin
    logic [31:0] rb;
    forever begin
      @(negedge clk_clk); #1;
      check("rst_out", 32'(rst_out), 32'(exp_rst));
      check("irq", 32'(irq), 32'(exp_irq));
      if (avs_readdatavalid) begin
        if (exp_q.size() == 0) check("spurious_rvalid", 32'(avs_readdatavalid), 32'd0);
        else begin
          rb = exp_q.pop_front();
          check("readdata", avs_readdata, rb);
        end
      end else if (exp_q.size() != 0) begin
        check("rvalid", 32'(avs_readdatavalid), 32'd1);
        exp_q.delete();
      end
    end
  end

  logic cnt_en = 1'b0;
  int   cnt_ch = 0;
  int   hi_cnt = 0;

  task automatic op(input logic rd, input logic wr, input logic [2:0] a, input logic [31:0] d);
    avs_read = rd; avs_write = wr; avs_address = a; avs_writedata = d;
    @(negedge clk_clk); #1;
    avs_read = 1'b0; avs_write = 1'b0;
    if (cnt_en) hi_cnt += int'(rst_out[cnt_ch]);
  endtask

  task automatic idle(input int n);
    repeat (n) op(1'b0, 1'b0, 3'd0, 32'd0);
  endtask

  task automatic pulse_width(input int ch, input logic [31:0] len, output int width);
    op(1'b0, 1'b1, A_LEN, len);
    cnt_ch = ch; hi_cnt = 0; cnt_en = 1'b1;
    op(1'b0, 1'b1, A_PULSE, 32'(1) << ch);
    op(1'b1, 1'b0, A_PULSE, 32'd0);
    idle(len[15:0] == 16'd0 ? 4 : int'(len[15:0]) + 4);
    op(1'b1, 1'b0, A_PULSE, 32'd0);
    cnt_en = 1'b0;
    width = hi_cnt;
  endtask

  initial begin
    int          w;
    logic [2:0]  a;
    logic [31:0] d;
    logic        rd, wr;
    int          b;

    repeat (3) @(negedge clk_clk);
    reset_reset = 1'b0;
    #1;
    check("rel_rst_out", 32'(rst_out), 32'hF);
    check("rel_irq", 32'(irq), 32'd0);
    check("rel_rdata", avs_readdata, 32'd0);
    check("rel_rvalid", 32'(avs_readdatavalid), 32'd0);
    op(1'b1, 1'b0, A_INFO, 32'd0);
    op(1'b1, 1'b0, A_LEN, 32'd0);
    op(1'b1, 1'b0, A_STAT, 32'd0);
    op(1'b1, 1'b0, 3'd7, 32'd0);

    op(1'b0, 1'b1, A_CTRL, 32'hFFFF_FFF0);
    check("ctrl_clear", 32'(rst_out), 32'h0);
    op(1'b1, 1'b0, A_CTRL, 32'd0);

    pulse_width(1, 32'h0000_0005, w);
    check("pulse5_width", 32'(w), 32'd5);

    op(1'b0, 1'b1, A_LEN, 32'd10);
    cnt_ch = 0; hi_cnt = 0; cnt_en = 1'b1;
    op(1'b0, 1'b1, A_PULSE, 32'h1);
    idle(3);
    op(1'b0, 1'b1, A_PULSE, 32'h1);
    idle(15);
    cnt_en = 1'b0;
    check("restart_width", 32'(hi_cnt), 32'd14);

    pulse_width(2, 32'hABCD_0000, w);
    check("zero_len_width", 32'(w), 32'd1);

    op(1'b0, 1'b1, A_MASK, 32'h4);
    lock_in[2] = 1'b0;
    idle(SYNC_STAGES);
    check("irq_before_loss", 32'(irq), 32'd0);
    idle(1);
    check("irq_on_loss", 32'(irq), 32'd1);
    op(1'b1, 1'b0, A_LOST, 32'd0);
    op(1'b0, 1'b1, A_LOST, 32'h4);
    check("irq_after_w1c", 32'(irq), 32'd0);
    lock_in[2] = 1'b1;
    idle(SYNC_STAGES + 2);

    op(1'b0, 1'b1, A_MASK, 32'h8);
    lock_in[3] = 1'b0;
    idle(SYNC_STAGES);
    op(1'b0, 1'b1, A_LOST, 32'h8);
    check("collision_irq", 32'(irq), 32'd1);
    op(1'b1, 1'b0, A_LOST, 32'd0);
    lock_in[3] = 1'b1;
    idle(SYNC_STAGES + 2);
    op(1'b0, 1'b1, A_LOST, 32'hF);
    check("collision_cleared", 32'(irq), 32'd0);

    op(1'b0, 1'b1, A_LEN, 32'd100);
    op(1'b0, 1'b1, A_PULSE, 32'hF);
    idle(30);
    op(1'b1, 1'b0, A_PULSE, 32'd0);
    #2;
    reset_reset = 1'b1;
    #1;
    check("midrst_rst_out", 32'(rst_out), 32'hF);
    check("midrst_rvalid", 32'(avs_readdatavalid), 32'd0);
    repeat (3) @(negedge clk_clk);
    reset_reset = 1'b0;
    #1;
    op(1'b0, 1'b1, A_CTRL, 32'd0);
    check("midrst_no_resume", 32'(rst_out), 32'h0);
    op(1'b1, 1'b0, A_PULSE, 32'd0);
    op(1'b1, 1'b0, A_MASK, 32'd0);
    op(1'b1, 1'b0, A_LEN, 32'd0);
    idle(4);

    for (int n = 0; n < 1500; n++) begin
      a  = 3'($urandom_range(0, 7));
      d  = $urandom;
      if (a == A_LEN) d[15:0] = 16'($urandom_range(0, 12));
      rd = ($urandom_range(0, 1) == 1);
      wr = ($urandom_range(0, 9) < 4);
      if ($urandom_range(0, 7) == 0) begin
        b = int'($urandom_range(0, NUM_CH - 1));
        lock_in[b] = ~lock_in[b];
      end
      op(rd, wr, a, d);
    end
    idle(20);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
